// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and framing constants for program_loader
// PROGRAM_LOADER_CHECKSUM_EN adds the CHECK state for the trailing XOR byte.
package loader_pkg;
   typedef enum logic [3:0] {
      IDLE, HDR_LO, HDR_HI, COLLECT, WRITE, FINISH,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK,
`endif
      DONE, ERROR
   } state_t;
   localparam int HDR_LEN = 2;
   function automatic int bytes_per_word(int ws);
      return ws / 8;
   endfunction
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte stream input and memory write port of the loader
interface program_loader_if #(
   parameter int WORD_SIZE  = 32,
   parameter int ADDR_WIDTH = 16
);
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [WORD_SIZE-1:0]  mem_data;
   logic                  mem_wren;
   modport master (output in_data, in_valid, input in_ready, mem_address, mem_data, mem_wren);
   modport slave  (input in_data, in_valid, output in_ready, mem_address, mem_data, mem_wren);
endinterface

// File: rtl/word_assembler.sv
// word_assembler: shifts little-endian bytes into a word, pulses word_ready on the last byte
module word_assembler import loader_pkg::*; #(
   parameter int WORD_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 byte_valid,
   input  logic [7:0]           byte_in,
   output logic [WORD_SIZE-1:0] word,
   output logic                 word_ready
);
   localparam int BPW = bytes_per_word(WORD_SIZE);
   localparam int CW  = BPW > 1 ? $clog2(BPW) : 1;
   logic [WORD_SIZE-1:0] shreg;
   logic [CW-1:0]        cnt;
   assign word       = (shreg >> 8) | (WORD_SIZE'(byte_in) << (WORD_SIZE - 8));
   assign word_ready = byte_valid && cnt == CW'(BPW - 1);
   // New bytes enter at the top lane so the first byte ends up in bits [7:0]
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (clear) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (byte_valid) begin
         shreg <= word;
         cnt   <= word_ready ? '0 : cnt + CW'(1);
      end
endmodule

// File: rtl/program_loader.sv
// program_loader: loads a length-prefixed byte stream into processor memory, holding the core meanwhile
// PROGRAM_LOADER_CHECKSUM_EN: expect a trailing XOR-of-payload byte before declaring success.
module program_loader import loader_pkg::*; #(
   parameter int WORD_SIZE      = 32,
   parameter int ADDR_WIDTH     = 16,
   parameter int BASE_ADDR      = 0,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   program_loader_if.slave bus,
   output logic            cpu_hold,
   output logic            busy,
   output logic            done,
   output logic            error,
   output logic [15:0]     words_written
);
   localparam logic [31:0] TLIM = 32'(TIMEOUT_CYCLES - 1);
   state_t               state, state_n;
   logic [15:0]          count;
   logic [31:0]          idle;
   logic [WORD_SIZE-1:0] word;
   logic                 acc, launch, word_ready, tmo;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]           xsum;
   assign bus.in_ready = state inside {HDR_LO, HDR_HI, COLLECT, CHECK};
`else
   assign bus.in_ready = state inside {HDR_LO, HDR_HI, COLLECT};
`endif
   assign acc      = bus.in_valid && bus.in_ready;
   assign launch   = start && (state inside {IDLE, DONE, ERROR});
   assign tmo      = TIMEOUT_CYCLES != 0 && bus.in_ready && !acc && idle == TLIM;
   assign busy     = !(state inside {IDLE, DONE, ERROR});
   assign done     = state == DONE;
   assign error    = state == ERROR;
   assign cpu_hold = busy || error;

   word_assembler #(.WORD_SIZE(WORD_SIZE)) u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear      (launch),
      .byte_valid (acc && state == COLLECT),
      .byte_in    (bus.in_data),
      .word       (word),
      .word_ready (word_ready)
   );

   // State register
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= state_n;

   // Next-state logic; a stalled stream overrides everything with ERROR
   always_comb begin
      state_n = state;
      case (state)
         IDLE, DONE, ERROR: if (start) state_n = HDR_LO;
         HDR_LO:  if (acc) state_n = HDR_HI;
         HDR_HI:  if (acc) state_n = {bus.in_data, count[7:0]} == 16'd0 ? FINISH : COLLECT;
         COLLECT: if (word_ready) state_n = WRITE;
         WRITE:   state_n = words_written + 16'd1 == count ? FINISH : COLLECT;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         FINISH:  state_n = CHECK;
         CHECK:   if (acc) state_n = bus.in_data == xsum ? DONE : ERROR;
`else
         FINISH:  state_n = DONE;
`endif
         default: state_n = IDLE;
      endcase
      if (tmo) state_n = ERROR;
   end

   // Header capture, word counting, idle timer and the registered write port
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         count           <= '0;
         words_written   <= '0;
         idle            <= '0;
         bus.mem_wren    <= 1'b0;
         bus.mem_address <= '0;
         bus.mem_data    <= '0;
      end else begin
         bus.mem_wren <= word_ready;
         idle         <= (acc || !bus.in_ready) ? '0 : idle + 32'd1;
         if (launch) begin
            count         <= '0;
            words_written <= '0;
         end
         if (acc && state == HDR_LO) count[7:0] <= bus.in_data;
         if (acc && state == HDR_HI) count[15:8] <= bus.in_data;
         if (state == WRITE) words_written <= words_written + 16'd1;
         if (word_ready) begin
            bus.mem_address <= ADDR_WIDTH'(BASE_ADDR + words_written);
            bus.mem_data    <= word;
         end
      end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   // Running XOR over payload bytes only
   always_ff @(posedge clk or negedge rst)
      if (!rst)                        xsum <= '0;
      else if (launch)                 xsum <= '0;
      else if (acc && state == COLLECT) xsum <= xsum ^ bus.in_data;
`endif
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed checks of program_loader; two instances share one stream (base 0 and base 0xFFFF)
module tb_program_loader;
   logic        clk = 0, rst = 1, start = 0, in_valid = 0;
   logic [7:0]  in_data = 0;
   logic        busy0, done0, error0, hold0, busy1, done1, error1, hold1;
   logic [15:0] ww0, ww1;
   int          n_checks = 0, n_fail = 0;
   logic [47:0] q0[$], q1[$];
   logic        prev0 = 0, prev1 = 0;
   logic [31:0] prog [2] = '{32'h00500013, 32'h00100093};
   logic [47:0] exp0 [2] = '{48'h0000_00500013, 48'h0001_00100093};
   logic [47:0] exp1 [2] = '{48'hFFFF_00500013, 48'h0000_00100093};

   program_loader_if #(.WORD_SIZE(32), .ADDR_WIDTH(16)) b0 ();
   program_loader_if #(.WORD_SIZE(32), .ADDR_WIDTH(16)) b1 ();
   assign b0.in_data  = in_data;
   assign b0.in_valid = in_valid;
   assign b1.in_data  = in_data;
   assign b1.in_valid = in_valid;

   program_loader #(.WORD_SIZE(32), .ADDR_WIDTH(16), .BASE_ADDR(0), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .start(start), .bus(b0),
      .cpu_hold(hold0), .busy(busy0), .done(done0), .error(error0), .words_written(ww0));
   program_loader #(.WORD_SIZE(32), .ADDR_WIDTH(16), .BASE_ADDR(16'hFFFF), .TIMEOUT_CYCLES(16)) dut_w (
      .clk(clk), .rst(rst), .start(start), .bus(b1),
      .cpu_hold(hold1), .busy(busy1), .done(done1), .error(error1), .words_written(ww1));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1;
      step();
      start = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t = 0;
      repeat (gap) step();
      in_data  = b;
      in_valid = 1;
      while (!b0.in_ready && t < 40) begin
         step();
         t++;
      end
      check("accept", {63'b0, b0.in_ready}, 1);
      step();
      in_valid = 0;
   endtask

   task automatic send_frame(input int n, input bit gaps);
      send_byte(8'(n), gaps ? int'($urandom_range(5)) : 0);
      send_byte(8'(n >> 8), gaps ? int'($urandom_range(5)) : 0);
      for (int w = 0; w < n; w++)
         for (int k = 0; k < 4; k++)
            send_byte(prog[w][8*k +: 8], gaps ? int'($urandom_range(5)) : 0);
   endtask

   task automatic wait_end();
      int t = 0;
      while (!done0 && !error0 && t < 20) begin
         step();
         t++;
      end
   endtask

   task automatic check_writes(input int n);
      check("n_writes0", q0.size(), n);
      check("n_writes1", q1.size(), n);
      for (int i = 0; i < n; i++) begin
         check("write0", i < q0.size() ? q0[i] : '1, exp0[i]);
         check("write1", i < q1.size() ? q1[i] : '1, exp1[i]);
      end
      q0.delete();
      q1.delete();
   endtask

   // Record writes, and check every write pulse is one cycle wide with the stream stalled
   always @(negedge clk) begin
      if (b0.mem_wren) begin
         check("wren_ready0", b0.in_ready, 0);
         check("wren_width0", prev0, 0);
         q0.push_back({b0.mem_address, b0.mem_data});
      end
      if (b1.mem_wren) begin
         check("wren_width1", prev1, 0);
         q1.push_back({b1.mem_address, b1.mem_data});
      end
      prev0 <= b0.mem_wren;
      prev1 <= b1.mem_wren;
   end

   initial begin
      #2 rst = 0;
      repeat (3) @(negedge clk);
      check("rst_hold", hold0, 0);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_error", error0, 0);
      check("rst_ww", ww0, 0);
      check("rst_ready", b0.in_ready, 0);
      check("rst_wren", b0.mem_wren, 0);
      check("rst_addr", b0.mem_address, 0);
      check("rst_data", b0.mem_data, 0);
      @(posedge clk);
      #1 rst = 1;
      step();

      pulse_start();
      check("basic_busy", busy0, 1);
      check("basic_hold", hold0, 1);
      send_frame(2, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(8'hC0, 0);
`endif
      wait_end();
      check("basic_done", done0, 1);
      check("basic_error", error0, 0);
      check("basic_hold_low", hold0, 0);
      check("basic_busy_low", busy0, 0);
      check("basic_ww0", ww0, 2);
      check("basic_ww1", ww1, 2);
      check("basic_done1", done1, 1);
      check_writes(2);

      pulse_start();
      check("empty_done_cleared", done0, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(8'h00, 0);
`else
      step();
`endif
      check("empty_done", done0, 1);
      check("empty_ww", ww0, 0);
      check_writes(0);

      pulse_start();
      send_frame(2, 1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(8'hC0, int'($urandom_range(5)));
`endif
      wait_end();
      check("gaps_done", done0, 1);
      check("gaps_ww", ww0, 2);
      check_writes(2);

      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      send_byte(8'h00, 0);
      send_byte(8'h50, 0);
      repeat (15) step();
      check("tmo_early_error", error0, 0);
      check("tmo_early_busy", busy0, 1);
      step();
      check("tmo_error", error0, 1);
      check("tmo_hold", hold0, 1);
      check("tmo_busy", busy0, 0);
      check("tmo_done", done0, 0);
      check_writes(0);
      repeat (3) step();
      check("tmo_error_stays", error0, 1);

      pulse_start();
      check("recover_error_cleared", error0, 0);
      send_frame(2, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(8'hC0, 0);
`endif
      wait_end();
      check("recover_done", done0, 1);
      check("recover_ww", ww0, 2);
      check_writes(2);

      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      send_byte(8'h00, 0);
      send_byte(8'h50, 0);
      send_byte(8'h00, 0);
      step();
      check("mid_writes", q0.size(), 1);
      rst = 0;
      #1;
      check("mid_busy", busy0, 0);
      check("mid_hold", hold0, 0);
      check("mid_ww", ww0, 0);
      check("mid_ready", b0.in_ready, 0);
      check("mid_addr0", b0.mem_address, 0);
      check("mid_data0", b0.mem_data, 0);
      check("mid_addr1", b1.mem_address, 0);
      check("mid_hold1", hold1, 0);
      repeat (3) step();
      check("mid_no_more_writes", q0.size(), 1);
      rst = 1;
      q0.delete();
      q1.delete();
      step();
      pulse_start();
      send_frame(2, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(8'hC0, 0);
`endif
      wait_end();
      check("wrap_done", done1, 1);
      check("wrap_ww", ww1, 2);
      check_writes(2);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      pulse_start();
      send_frame(2, 0);
      send_byte(8'hC1, 0);
      wait_end();
      check("bad_sum_error", error0, 1);
      check("bad_sum_hold", hold0, 1);
      check("bad_sum_done", done0, 0);
      check_writes(2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream program loader; writes the instruction image into processor_memory through its write port (address/data/wren).
- The processor core is the memory reader; this block is the writer. It holds the core in reset via cpu_hold while loading.
- Input is a generic 8-bit valid/ready stream, sourced from a UART/GPIO front end.
- Runs on the same clk/rst as the core.

Parameters:
- WORD_SIZE, 32, memory word width in bits; must be a multiple of 8. BYTES_PER_WORD = WORD_SIZE/8.
- ADDR_WIDTH, 16, memory address width.
- BASE_ADDR, 0, word address of the first write.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between accepted bytes during a load; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- start  input  1  single-cycle pulse that begins a load
- in_data  input  8  stream byte
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts a byte this cycle
- mem_address  output  ADDR_WIDTH  write word address
- mem_data  output  WORD_SIZE  write data
- mem_wren  output  1  write enable, one cycle per word
- cpu_hold  output  1  high while busy or in error; gate the core reset with it
- busy  output  1  load in progress
- done  output  1  last load completed successfully (level)
- error  output  1  last load failed (level)
- words_written  output  16  words written in current or last load

Behaviour:
- Byte transfer occurs only when in_valid && in_ready. in_ready is combinational from state only and never depends on in_valid.
- Frame format:
  - 2-byte little-endian word count N.
  - Then N*BYTES_PER_WORD payload bytes, little-endian within each word: payload byte k of a word goes to bits [8k+7:8k].
- Reset values: all outputs 0, state IDLE, all counters and the assembly register 0.
- States:
  - IDLE: in_ready=0. start -> HDR_LO; clear count, index, byte counter and words_written; busy=1, cpu_hold=1 from the next cycle.
  - HDR_LO: in_ready=1. Accepted byte -> count[7:0]; go to HDR_HI.
  - HDR_HI: in_ready=1. Accepted byte -> count[15:8]. If the full count is 0, go to FINISH; else go to COLLECT.
  - COLLECT: in_ready=1. Each accepted byte is placed into the assembly register. After BYTES_PER_WORD accepted bytes, go to WRITE.
  - WRITE: in_ready=0; mem_wren=1 for exactly one cycle.
    - mem_address = (BASE_ADDR + index) mod 2^ADDR_WIDTH.
    - mem_data = assembled word.
    - Next cycle: index+1 and words_written+1. If index+1 == count, go to FINISH; else go to COLLECT.
  - FINISH: go to DONE (without macro) or CHECK (with macro).
  - DONE: done=1, busy=0, cpu_hold=0. start -> HDR_LO and clears done.
  - ERROR: error=1, busy=0, cpu_hold=1. Leaves only on start (-> HDR_LO, clears error) or reset.
- Write latency: mem_wren asserts in the cycle after the last byte of a word is accepted. Maximum throughput is one byte per cycle, plus one WRITE cycle per word.
- Timeout: idle counter runs in HDR_LO, HDR_HI, COLLECT and CHECK. It clears on every accepted byte. On reaching TIMEOUT_CYCLES -> ERROR, with no partial-word write.
- start while busy is ignored.
- Outside WRITE: mem_wren=0; mem_address and mem_data hold their last values.
- Address wrap-around is silent (modulo 2^ADDR_WIDTH).
- Asynchronous reset mid-load: immediate return to reset values. No further writes occur; memory keeps any words already written.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- With the macro:
  - A running XOR of all payload bytes is kept; header bytes are excluded.
  - FINISH -> CHECK, with in_ready=1. One trailing byte is accepted.
  - Trailing byte equal to the XOR -> DONE; otherwise -> ERROR.
  - For N=0 the expected checksum is 0x00.
- Without the macro: no CHECK state, no XOR register; FINISH -> DONE directly.

Decomposition:
- Package loader_pkg holds:
  - the state encoding: IDLE, HDR_LO, HDR_HI, COLLECT, WRITE, FINISH, CHECK, DONE, ERROR;
  - BYTES_PER_WORD;
  - the header length constant (2).
- Sub-module word_assembler contains:
  - the byte-lane shift register and byte counter;
  - a word_ready pulse output;
  - a clear input.
  The FSM, address generation and timeout stay in the top level.

Test Plan:
- Basic load: start, then bytes 02 00 13 00 50 00 93 00 10 00 -> two writes (addr 0 data 0x00500013, then addr 1 data 0x00100093); done=1; cpu_hold falls; words_written=2.
- Empty frame: header 00 00 -> no mem_wren; done=1 within 2 cycles of the last header byte.
- Backpressure and gaps: same frame with random in_valid gaps of 0-5 cycles -> identical writes. mem_wren pulses are exactly 1 cycle wide; in_ready=0 during WRITE.
- Timeout: TIMEOUT_CYCLES=16, stop after 3 bytes of the first word -> error=1 exactly 16 cycles after the last accepted byte; no mem_wren; cpu_hold stays 1. A new start recovers.
- Reset mid-load: assert rst after the first word is written -> all outputs 0 immediately. A subsequent full load with BASE_ADDR=0xFFFF, N=2 writes addr 0xFFFF then addr 0x0000.
- PROGRAM_LOADER_CHECKSUM_EN: the basic frame followed by checksum byte 0xC0 (XOR of the 8 payload bytes) -> done. Trailing byte 0xC1 -> error, with both words still written.
